// File: rtl/conv_rstl_addr_gen.sv
// rtl/conv_rstl_addr_gen.sv - write-address generator walking a CHANNELS x ROWS x COLS result volume
module conv_rstl_addr_gen #(
  parameter int ROWS     = 26,
  parameter int COLS     = 26,
  parameter int CHANNELS = 1,
  parameter int ADDR_W   = 10,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5,
  parameter int CH_W     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [CH_W-1:0]   ch,
  output logic              busy,
  output logic              last,
  output logic              frame_done,
  output logic              done
);

  if (CHANNELS * ROWS * COLS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("conv_rstl_addr_gen: ADDR_W too small for CHANNELS*ROWS*COLS");
  end
  if (ROWS > (1 << ROW_W) || COLS > (1 << COL_W) || CHANNELS > (1 << CH_W)) begin : g_bad_idx_w
    $error("conv_rstl_addr_gen: index width too small");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [ROW_W-1:0]  row_n;
  logic [COL_W-1:0]  col_n;
  logic [CH_W-1:0]   ch_n;
  logic [ADDR_W-1:0] lin_q, lin_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic              cont_q, cont_n;
  logic              frame_done_n;
  logic              at_end;

  assign at_end = (col == COL_W'(COLS - 1)) && (row == ROW_W'(ROWS - 1)) &&
                  (ch == CH_W'(CHANNELS - 1));
  assign last   = busy && at_end;

  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    ch_n         = ch;
    lin_n        = lin_q;
    base_n       = base_q;
    cont_n       = cont_q;
    frame_done_n = 1'b0;
    if (abort) begin
      // Abort also drops the latched base so addr reads 0 while idle
      state_n = IDLE;
      row_n   = '0;
      col_n   = '0;
      ch_n    = '0;
      lin_n   = '0;
      base_n  = '0;
      cont_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          row_n = '0;
          col_n = '0;
          ch_n  = '0;
          lin_n = '0;
          if (start) begin
            base_n  = base_addr;
            cont_n  = continuous;
            state_n = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (at_end) begin
              row_n        = '0;
              col_n        = '0;
              ch_n         = '0;
              lin_n        = '0;
              frame_done_n = 1'b1;
              if (!cont_q) state_n = DONE;
            end else begin
              lin_n = lin_q + ADDR_W'(1);
              if (col == COL_W'(COLS - 1)) begin
                col_n = '0;
                if (row == ROW_W'(ROWS - 1)) begin
                  row_n = '0;
                  ch_n  = ch + CH_W'(1);
                end else begin
                  row_n = row + ROW_W'(1);
                end
              end else begin
                col_n = col + COL_W'(1);
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      ch         <= '0;
      lin_q      <= '0;
      base_q     <= '0;
      cont_q     <= 1'b0;
      addr       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      ch         <= ch_n;
      lin_q      <= lin_n;
      base_q     <= base_n;
      cont_q     <= cont_n;
      addr       <= base_n + lin_n;
      busy       <= (state_n == RUN);
      frame_done <= frame_done_n;
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_conv_rstl_addr_gen.sv
// tb/tb_conv_rstl_addr_gen.sv - randomized and directed bench for three conv_rstl_addr_gen configurations
module tb_conv_rstl_addr_gen;

  logic       clk = 1'b0;
  logic       rst, start, continuous, abort, en;
  logic [9:0] base_addr;

  always #5 clk = ~clk;

  // config 0: 2x3x2, config 1: default 26x26x1, config 2: 1x1x1
  logic [9:0] a_addr, b_addr, c_addr;
  logic       a_row, c_row, c_col;
  logic [1:0] a_col;
  logic [4:0] b_row, b_col;
  logic       a_ch, b_ch, c_ch;
  logic [2:0] a_flags, b_flags, c_flags;
  logic       a_last, b_last, c_last;

  conv_rstl_addr_gen #(.ROWS(2), .COLS(3), .CHANNELS(2), .ADDR_W(10), .ROW_W(1), .COL_W(2), .CH_W(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort), .en(en),
    .base_addr(base_addr), .addr(a_addr), .row(a_row), .col(a_col), .ch(a_ch),
    .busy(a_flags[0]), .last(a_last), .frame_done(a_flags[1]), .done(a_flags[2]));

  conv_rstl_addr_gen dut_b (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort), .en(en),
    .base_addr(base_addr), .addr(b_addr), .row(b_row), .col(b_col), .ch(b_ch),
    .busy(b_flags[0]), .last(b_last), .frame_done(b_flags[1]), .done(b_flags[2]));

  conv_rstl_addr_gen #(.ROWS(1), .COLS(1), .CHANNELS(1), .ADDR_W(10), .ROW_W(1), .COL_W(1), .CH_W(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort), .en(en),
    .base_addr(base_addr), .addr(c_addr), .row(c_row), .col(c_col), .ch(c_ch),
    .busy(c_flags[0]), .last(c_last), .frame_done(c_flags[1]), .done(c_flags[2]));

  int checks = 0;
  int failures = 0;

  int R[3] = '{2, 26, 1};
  int C[3] = '{3, 26, 1};
  int N[3] = '{2, 1, 1};

  // model: 0 idle, 1 run, 2 done; position kept as a plain linear index
  int m_state[3], m_pos[3], m_base[3], m_cont[3], m_fd[3], m_done[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int total;
      total = R[k] * C[k] * N[k];
      m_fd[k] = 0;
      m_done[k] = 0;
      if (rst) begin
        m_state[k] = 0; m_pos[k] = 0; m_base[k] = 0; m_cont[k] = 0;
      end else if (abort) begin
        m_state[k] = 0; m_pos[k] = 0; m_base[k] = 0; m_cont[k] = 0;
      end else if (m_state[k] == 0) begin
        if (start) begin
          m_state[k] = 1; m_base[k] = int'(base_addr); m_cont[k] = int'(continuous);
        end
      end else if (m_state[k] == 1) begin
        if (en) begin
          if (m_pos[k] == total - 1) begin
            m_pos[k] = 0;
            m_fd[k] = 1;
            if (m_cont[k] == 0) begin
              m_state[k] = 2; m_done[k] = 1;
            end
          end else begin
            m_pos[k]++;
          end
        end
      end else begin
        m_state[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [9:0]  o_addr[3];
    logic [31:0] o_row[3], o_col[3], o_ch[3];
    logic [2:0]  o_flags[3];
    logic        o_last[3];
    o_addr = '{a_addr, b_addr, c_addr};
    o_row  = '{32'(a_row), 32'(b_row), 32'(c_row)};
    o_col  = '{32'(a_col), 32'(b_col), 32'(c_col)};
    o_ch   = '{32'(a_ch), 32'(b_ch), 32'(c_ch)};
    o_flags = '{a_flags, b_flags, c_flags};
    o_last = '{a_last, b_last, c_last};
    for (int k = 0; k < 3; k++) begin
      int p;
      p = m_pos[k];
      chk($sformatf("addr[%0d]", k), 32'(o_addr[k]), 32'((m_base[k] + p) % 1024));
      chk($sformatf("col[%0d]", k), o_col[k], 32'(p % C[k]));
      chk($sformatf("row[%0d]", k), o_row[k], 32'((p / C[k]) % R[k]));
      chk($sformatf("ch[%0d]", k), o_ch[k], 32'(p / (R[k] * C[k])));
      chk($sformatf("busy[%0d]", k), 32'(o_flags[k][0]), 32'(m_state[k] == 1));
      chk($sformatf("frame_done[%0d]", k), 32'(o_flags[k][1]), 32'(m_fd[k]));
      chk($sformatf("done[%0d]", k), 32'(o_flags[k][2]), 32'(m_done[k]));
      chk($sformatf("last[%0d]", k), 32'(o_last[k]),
          32'(m_state[k] == 1 && p == R[k] * C[k] * N[k] - 1));
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input logic s, input logic c, input logic a, input logic e, input logic [9:0] b);
    start = s; continuous = c; abort = a; en = e; base_addr = b;
  endtask

  int fd_cnt, done_cnt;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 10'h0);
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_addr", 32'(a_addr), 32'h0);
    chk("reset_busy", 32'(a_flags[0]), 32'h0);

    // single-shot, en held high
    set_in(1, 0, 0, 0, 10'h100); cyc();
    chk("start_busy", 32'(a_flags[0]), 32'h1);
    chk("c_last_on_busy", 32'(c_last), 32'h1);
    set_in(0, 0, 0, 1, 10'h3ff);
    for (int i = 0; i < 12; i++) begin
      chk("seq_addr", 32'(a_addr), 32'(10'h100 + i));
      cyc();
    end
    chk("done_pulse", 32'(a_flags[2]), 32'h1);
    chk("fd_pulse", 32'(a_flags[1]), 32'h1);
    chk("busy_fall", 32'(a_flags[0]), 32'h0);
    set_in(0, 0, 1, 0, 10'h0); cyc();

    // continuous mode, 30 en cycles
    set_in(1, 1, 0, 0, 10'h100); cyc();
    set_in(0, 0, 0, 1, 10'h0);
    fd_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      fd_cnt += int'(a_flags[1]);
      done_cnt += int'(a_flags[2]);
    end
    chk("cont_fd_count", 32'(fd_cnt), 32'd2);
    chk("cont_done_count", 32'(done_cnt), 32'd0);
    chk("cont_busy", 32'(a_flags[0]), 32'h1);
    set_in(0, 0, 1, 0, 10'h0); cyc();

    // default config, en every other cycle
    set_in(1, 0, 0, 0, 10'h0); cyc();
    set_in(0, 0, 0, 0, 10'h0);
    for (int i = 0; i < 2 * 676 - 1; i++) begin
      en = i[0];
      cyc();
    end
    chk("b_addr_675", 32'(b_addr), 32'd675);
    chk("b_row_25", 32'(b_row), 32'd25);
    chk("b_col_25", 32'(b_col), 32'd25);
    en = 1'b1; cyc();
    chk("b_done", 32'(b_flags[2]), 32'h1);
    set_in(0, 0, 0, 0, 10'h0); cyc(); cyc();

    // mid-frame abort with en, then restart at a new base
    set_in(1, 0, 0, 0, 10'h2f0); cyc();
    set_in(0, 0, 0, 1, 10'h0);
    for (int i = 0; i < 5; i++) cyc();
    set_in(0, 0, 1, 1, 10'h0); cyc();
    chk("abort_addr", 32'(a_addr), 32'h0);
    chk("abort_busy", 32'(a_flags[0]), 32'h0);
    set_in(1, 0, 0, 0, 10'h055); cyc();
    chk("restart_addr", 32'(a_addr), 32'h055);

    // start during RUN ignored
    set_in(1, 1, 0, 1, 10'h123); cyc(); cyc();
    set_in(0, 0, 1, 0, 10'h0); cyc();
    // en in IDLE ignored
    set_in(0, 0, 0, 1, 10'h0); cyc(); cyc();

    // rst mid-frame together with start and en
    set_in(1, 0, 0, 0, 10'h200); cyc();
    set_in(0, 0, 0, 1, 10'h0); cyc(); cyc();
    rst = 1'b1; set_in(1, 1, 0, 1, 10'h3aa); cyc();
    rst = 1'b0;
    chk("rst_addr", 32'(a_addr), 32'h0);
    set_in(0, 0, 0, 0, 10'h0); cyc();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) < 7, 10'($urandom));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_rstl_addr_gen.md
Name: conv_rstl_addr_gen

Overview:
Parametrised write-address generator for the convolution-result memory, generalising the single-channel 676-entry position counter.
- Walks a CHANNELS x ROWS x COLS result volume in column, then row, then channel order.
- Exposes both the linear address and the (ch, row, col) coordinates.
- Has a start/busy/done handshake, abort, and single-shot or continuous mode.
- Sits between the convolution datapath, which pulses en once per produced result, and the result RAM / maxpooling stage.

Parameters:
ROWS, 26, output rows per channel (>=1)
COLS, 26, output columns per channel (>=1)
CHANNELS, 1, number of output channels / feature maps (>=1)
ADDR_W, 10, address width; must satisfy 2^ADDR_W >= CHANNELS*ROWS*COLS
ROW_W, 5, row index width; 2^ROW_W >= ROWS
COL_W, 5, column index width; 2^COL_W >= COLS
CH_W, 1, channel index width; 2^CH_W >= CHANNELS (minimum 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a pass; sampled only in IDLE
continuous  in  1  sampled with start; 1 = wrap and keep running after each frame
abort  in  1  return to IDLE at next edge, counters cleared
en  in  1  one result consumed at current address; advances position
base_addr  in  ADDR_W  offset added to linear position; latched on accepted start
addr  out  ADDR_W  base + linear position of the current write slot
row  out  ROW_W  current row index
col  out  COL_W  current column index
ch  out  CH_W  current channel index
busy  out  1  high in RUN
last  out  1  combinational: busy and position is (CHANNELS-1, ROWS-1, COLS-1)
frame_done  out  1  one-cycle pulse after the final position is consumed (both modes)
done  out  1  one-cycle pulse on entering DONE (single-shot only)

Behaviour:
- Reset: state=IDLE. Outputs after reset: row=col=ch=0, linear=0, addr=0, busy=0, frame_done=0, done=0, latched base=0, latched mode=0. rst has priority over abort, start and en.
- Every outputs except last is registered. addr = base_q + linear, computed with an ADDR_W-bit wrapping add.
- States:
  - IDLE: counters held at 0. en ignored. A start pulse latches base_addr and continuous, then moves to RUN. busy rises in the cycle after start.
  - RUN: each cycle with en=1 advances the position by one step:
    - col increments.
    - When col=COLS-1: col=0, row increments.
    - When also row=ROWS-1: row=0, ch increments.
    - linear increments alongside the coordinates. No multiplier is used.
    - Latency: position advances at the edge where en is sampled, so the new addr is visible the next cycle.
  - Final position (last=1) consumed with en=1:
    - All counters return to 0 and frame_done pulses for one cycle.
    - continuous=1: stay in RUN; the next frame starts immediately with no lost cycle.
    - continuous=0: go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start in RUN or DONE: ignored; no re-latch of base_addr or mode.
- abort (not in reset), any state: next state IDLE, counters 0, no done/frame_done pulse. abort overrides a simultaneous en or start.
- Degenerate sizes:
  - COLS=1: row advances on every en.
  - ROWS=COLS=CHANNELS=1: last is high for the whole of RUN; one en completes the frame.
- en held high continuously: one address per cycle, no bubbles, including across frame wrap in continuous mode.
- Widths: assert at elaboration (simulation check) that CHANNELS*ROWS*COLS <= 2^ADDR_W and that the index widths fit.

Test Plan:
- ROWS=2, COLS=3, CHANNELS=2, base=0x100, start, en held high -> addr sequence 0x100..0x10B, one per cycle. (row,col) runs (0,0),(0,1),(0,2),(1,0)..(1,2), then ch becomes 1. last high only at 0x10B. frame_done and done pulse together one cycle later; busy falls on that cycle.
- Same config with continuous=1, en high for 30 cycles -> addr wraps 0x10B->0x100 with no gap. frame_done pulses exactly twice. done never asserts. busy stays high.
- Default 26x26x1, base=0, en toggled every other cycle -> addr advances only on en cycles and reaches 675 with row=25, col=25. done follows the 676th en.
- Mid-frame abort after 5 en pulses, asserted together with en -> next cycle IDLE, addr=0, busy=0, no done. A following start restarts at the new base.
- start pulses during RUN, and en in IDLE -> no effect: base not re-latched, counters do not move. rst asserted mid-frame together with start and en -> all outputs at reset values next cycle.
- ROWS=COLS=CHANNELS=1 -> last high as soon as busy rises. A single en gives frame_done and done one cycle later.
